// File: rtl/hack_mmio_hub_if.sv
// CPU-side bus of the Hack MMIO hub: address/data/write strobe, the
// per-Hack-cycle commit strobe, combinational read data and window select.
interface hack_mmio_hub_if #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 15
);
  logic                     hack_commit;
  logic [ADDRESS_WIDTH-1:0] hack_addressM;
  logic                     hack_writeM;
  logic [WORD_WIDTH-1:0]    hack_outM;
  logic [WORD_WIDTH-1:0]    hack_inM;
  logic                     mmio_sel;

  modport master (
    output hack_commit, hack_addressM, hack_writeM, hack_outM,
    input  hack_inM, mmio_sel
  );

  modport slave (
    input  hack_commit, hack_addressM, hack_writeM, hack_outM,
    output hack_inM, mmio_sel
  );
endinterface

// File: rtl/hack_mmio_hub.sv
// hack_mmio_hub: memory-mapped I/O block for the Hack SoC.
// Offset map from MMIO_BASE: 0 KBD, 1 KSTAT, 2..2+N-1 GPIO[k], 2+N TIMER,
// 3+N TCTRL. Keyboard FIFO, GPIO output registers and, when the macro
// HACK_MMIO_TIMER_EN is defined, a prescaled free-running timer.
module hack_mmio_hub #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDRESS_WIDTH  = 15,
  parameter int unsigned MMIO_BASE      = 24576,
  parameter int unsigned GPIO_CHANNELS  = 2,
  parameter int unsigned KBD_FIFO_DEPTH = 4,
  parameter int unsigned TIMER_PRESCALE = 100
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                hack_reset,
  hack_mmio_hub_if.slave                      bus,
  input  logic                                key_valid,
  input  logic [7:0]                          key_code,
  output logic [GPIO_CHANNELS*WORD_WIDTH-1:0] gpio_o,
  output logic                                timer_wrap
);

  localparam int unsigned PTR_W = $clog2(KBD_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(MMIO_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_KBD   = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_KSTAT = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_TCTRL = ADDRESS_WIDTH'(3 + GPIO_CHANNELS);
  localparam logic [CNT_W-1:0]         FULL_CNT  = CNT_W'(KBD_FIFO_DEPTH);

  if (GPIO_CHANNELS < 1 || GPIO_CHANNELS > 8) begin : g_bad_gpio
    $error("GPIO_CHANNELS must be 1..8");
  end
  if (KBD_FIFO_DEPTH < 2 || (KBD_FIFO_DEPTH & (KBD_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("KBD_FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (TIMER_PRESCALE < 1) begin : g_bad_prescale
    $error("TIMER_PRESCALE must be >= 1");
  end

  // ---------------- address decode ----------------
  logic [ADDRESS_WIDTH-1:0] off;
  logic                     wr_en;

  assign off          = bus.hack_addressM - BASE;
  assign bus.mmio_sel = (bus.hack_addressM >= BASE) && (off <= OFF_TCTRL);
  assign wr_en        = bus.hack_commit && bus.hack_writeM && bus.mmio_sel && !hack_reset;

  // ---------------- keyboard FIFO ----------------
  logic [7:0]       mem [KBD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             empty, full, do_pop, do_push, ovf_set, ovf_clr;
  logic [WORD_WIDTH-1:0] kstat;

  // Push/pop arbitration: a pop frees the slot so a push into a full FIFO
  // in the same cycle is accepted without overflow.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_pop  = wr_en && (off == OFF_KSTAT) && bus.hack_outM[0] && !empty;
    ovf_clr = wr_en && (off == OFF_KSTAT) && bus.hack_outM[2];
    do_push = key_valid && (!full || do_pop);
    ovf_set = key_valid && full && !do_pop;
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since empty reads return 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= key_code;
  end

  // KSTAT status word assembly.
  always_comb begin
    kstat              = '0;
    kstat[0]           = !empty;
    kstat[1]           = full;
    kstat[2]           = overflow;
    kstat[3 +: CNT_W]  = count;
  end

  // ---------------- GPIO ----------------
  logic [WORD_WIDTH-1:0] gpio [GPIO_CHANNELS];

  // GPIO registers: cleared by either reset, loaded on committed writes.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < GPIO_CHANNELS; k++) begin
      if (reset || hack_reset) gpio[k] <= '0;
      else if (wr_en && off == ADDRESS_WIDTH'(2 + k)) gpio[k] <= bus.hack_outM;
    end
  end

  // Flatten GPIO registers onto the output bus.
  always_comb begin
    gpio_o = '0;
    for (int unsigned k = 0; k < GPIO_CHANNELS; k++) gpio_o[k*WORD_WIDTH +: WORD_WIDTH] = gpio[k];
  end

  // ---------------- timer ----------------
`ifdef HACK_MMIO_TIMER_EN
  localparam int unsigned PS_W = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] OFF_TIMER = ADDRESS_WIDTH'(2 + GPIO_CHANNELS);
  localparam logic [PS_W-1:0]          PS_LAST   = PS_W'(TIMER_PRESCALE - 1);

  logic [WORD_WIDTH-1:0] timer;
  logic [PS_W-1:0]       ps;
  logic                  t_en, t_wrapped;
  logic                  tick, timer_wr, tctrl_wr, wrap_now;

  // Tick and wrap detection; a TIMER write overrides the increment.
  always_comb begin
    tick     = t_en && (ps == PS_LAST);
    timer_wr = wr_en && (off == OFF_TIMER);
    tctrl_wr = wr_en && (off == OFF_TCTRL);
    wrap_now = tick && !timer_wr && (timer == '1);
  end

  // Prescaler, timer value, control bits and registered wrap pulse.
  always_ff @(posedge clk) begin
    if (reset || hack_reset) begin
      timer      <= '0;
      ps         <= '0;
      t_en       <= 1'b0;
      t_wrapped  <= 1'b0;
      timer_wrap <= 1'b0;
    end else begin
      timer_wrap <= wrap_now;
      if (timer_wr) begin
        timer <= bus.hack_outM;
        ps    <= '0;
      end else if (t_en) begin
        ps <= tick ? '0 : ps + 1'b1;
        if (tick) timer <= timer + 1'b1;
      end
      if (tctrl_wr) t_en <= bus.hack_outM[0];
      if (wrap_now)                          t_wrapped <= 1'b1;
      else if (tctrl_wr && bus.hack_outM[1]) t_wrapped <= 1'b0;
    end
  end
`else
  assign timer_wrap = 1'b0;
`endif

  // ---------------- read mux ----------------
  // Purely combinational from address and registers; reads never pop.
  always_comb begin
    bus.hack_inM = '0;
    if (bus.mmio_sel) begin
      if (off == OFF_KBD && !empty) bus.hack_inM = WORD_WIDTH'(mem[rd_ptr]);
      if (off == OFF_KSTAT)         bus.hack_inM = kstat;
      for (int unsigned k = 0; k < GPIO_CHANNELS; k++) begin
        if (off == ADDRESS_WIDTH'(2 + k)) bus.hack_inM = gpio[k];
      end
`ifdef HACK_MMIO_TIMER_EN
      if (off == OFF_TIMER) bus.hack_inM = timer;
      if (off == OFF_TCTRL) bus.hack_inM = WORD_WIDTH'({t_wrapped, t_en});
`endif
    end
  end

endmodule
